// File: rtl/codificador_prioridade_8x3.sv
// Registered priority encoder. Request pulses on the a lines are captured
// into a sticky pending vector. Pending requests are issued one at a time as
// W-bit codes over a valid/ready handshake. The en input gates issuing only;
// capture of new requests continues while en=0.
module codificador_prioridade_8x3 #(
  parameter int W        = 3,
  parameter bit PRIO_MSB = 1'b1,
  localparam int N       = 2**W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [N-1:0] a,
  input  logic         ready,
  output logic [W-1:0] y,
  output logic         valid,
  output logic [N-1:0] pend,
  output logic         nenhum,
  output logic         perdido
);

  typedef enum logic {
    IDLE   = 1'b0,
    OFERTA = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pend_q, pend_d;
  logic [W-1:0] y_q, y_d;
  logic         perdido_q, perdido_d;

  logic [W-1:0] sel;
  logic         issue;
  logic [N-1:0] clr;

  // Priority pick over the registered pending vector. Requests arriving this
  // cycle are not candidates until the next edge.
  always_comb begin
    // NOTE: give every combinational output a default before any branch, so
    // no path leaves it unassigned and no latch is inferred.
    sel = '0;
    if (PRIO_MSB) begin
      for (int i = 0; i < N; i++)
        if (pend_q[i]) sel = W'(i);
    end else begin
      for (int i = N - 1; i >= 0; i--)
        if (pend_q[i]) sel = W'(i);
    end
  end

  // State, pending vector, code and loss-pulse registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before this edge, independent of statement order.
    if (rst) begin
      state_q   <= IDLE;
      pend_q    <= '0;
      y_q       <= '0;
      perdido_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      y_q       <= y_d;
      perdido_q <= perdido_d;
    end
  end

  // Next state: decide whether a code is issued at this edge and update the
  // pending vector (a new request on the issued index wins over its clear).
  always_comb begin
    issue   = en && (|pend_q) && ((state_q == IDLE) || ready);
    clr     = issue ? (N'(1) << sel) : '0;
    pend_d  = (pend_q & ~clr) | a;
    // A request on the index being issued now is a fresh request, not a loss.
    perdido_d = |(a & pend_q & ~clr);
    y_d     = issue ? sel : y_q;
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = OFERTA;
      OFERTA:  if (ready) state_d = issue ? OFERTA : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs: all derived from registers only.
  always_comb begin
    y       = y_q;
    valid   = (state_q == OFERTA);
    pend    = pend_q;
    perdido = perdido_q;
    nenhum  = (state_q == IDLE) && (pend_q == '0);
  end

endmodule

// File: tb/tb_codificador_prioridade_8x3.sv
// Directed bench for codificador_prioridade_8x3. A second instance with
// PRIO_MSB=0 shares the inputs to check the lowest-index-first order.
module tb_codificador_prioridade_8x3;

  logic       clk;
  logic       rst;
  logic       en;
  logic [7:0] a;
  logic       ready;

  logic [2:0] y,       y_l;
  logic       valid,   valid_l;
  logic [7:0] pend,    pend_l;
  logic       nenhum,  nenhum_l;
  logic       perdido, perdido_l;

  int n_checks = 0;
  int n_pass   = 0;

  codificador_prioridade_8x3 #(.W(3), .PRIO_MSB(1'b1)) dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .ready(ready),
    .y(y), .valid(valid), .pend(pend), .nenhum(nenhum), .perdido(perdido)
  );

  codificador_prioridade_8x3 #(.W(3), .PRIO_MSB(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .en(en), .a(a), .ready(ready),
    .y(y_l), .valid(valid_l), .pend(pend_l), .nenhum(nenhum_l), .perdido(perdido_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one rising edge; outputs are sampled and inputs driven 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; a = 8'h00; ready = 1'b0;

    // 1: reset for two cycles
    tick(); tick();
    check("rst_valid",   valid,   1'b0);
    check("rst_y",       y,       3'd0);
    check("rst_pend",    pend,    8'h00);
    check("rst_nenhum",  nenhum,  1'b1);
    check("rst_perdido", perdido, 1'b0);
    rst = 1'b0;

    // 2: three simultaneous requests, issued in priority order
    ready = 1'b1; a = 8'b1001_0100;
    tick(); a = 8'h00;
    check("t2_pend",   pend,  8'h94);
    check("t2_valid0", valid, 1'b0);
    tick();
    check("t2_v1", valid, 1'b1); check("t2_y1", y, 3'd7); check("t2_l1", y_l, 3'd2);
    tick();
    check("t2_v2", valid, 1'b1); check("t2_y2", y, 3'd4); check("t2_l2", y_l, 3'd4);
    tick();
    check("t2_v3", valid, 1'b1); check("t2_y3", y, 3'd2); check("t2_l3", y_l, 3'd7);
    tick();
    check("t2_done_valid", valid, 1'b0);
    check("t2_done_nenhum", nenhum, 1'b1);
    check("t2_done_valid_l", valid_l, 1'b0);

    // 3: offer held stable while ready=0, new request queued behind it
    ready = 1'b0; a = 8'h20;
    tick(); a = 8'h00;
    tick();
    check("t3_valid", valid, 1'b1); check("t3_y", y, 3'd5); check("t3_pend0", pend, 8'h00);
    a = 8'h80;
    tick(); a = 8'h00;
    check("t3_hold_y", y, 3'd5); check("t3_pend", pend, 8'h80);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_hold_valid", valid, 1'b1);
      check("t3_hold_y", y, 3'd5);
    end
    ready = 1'b1;
    tick();
    check("t3_next_valid", valid, 1'b1); check("t3_next_y", y, 3'd7);
    check("t3_next_pend", pend, 8'h00);
    tick();
    check("t3_end_valid", valid, 1'b0);

    // 4: repeated request on a pending bit reports a loss; en=0 blocks issuing
    en = 1'b0; a = 8'h08;
    tick(); check("t4_perdido0", perdido, 1'b0); check("t4_pend", pend, 8'h08);
    tick(); check("t4_perdido1", perdido, 1'b1);
    tick(); check("t4_perdido2", perdido, 1'b1);
    a = 8'h00;
    tick(); check("t4_perdido3", perdido, 1'b0); check("t4_valid", valid, 1'b0);
    check("t4_pend2", pend, 8'h08);
    en = 1'b1; ready = 1'b1;
    tick(); check("t4_issue_valid", valid, 1'b1); check("t4_issue_y", y, 3'd3);
    check("t4_issue_pend", pend, 8'h00);
    tick(); check("t4_end_valid", valid, 1'b0);

    // 5: capture while disabled, then drain four codes back to back
    en = 1'b0; a = 8'h0F;
    tick(); a = 8'h00;
    check("t5_pend", pend, 8'h0F); check("t5_valid", valid, 1'b0);
    tick(); check("t5_blocked", valid, 1'b0);
    en = 1'b1;
    tick(); check("t5_v3", valid, 1'b1); check("t5_y3", y, 3'd3);
    tick(); check("t5_v2", valid, 1'b1); check("t5_y2", y, 3'd2);
    tick(); check("t5_v1", valid, 1'b1); check("t5_y1", y, 3'd1);
    tick(); check("t5_v0", valid, 1'b1); check("t5_y0", y, 3'd0);
    tick(); check("t5_end_valid", valid, 1'b0); check("t5_end_nenhum", nenhum, 1'b1);

    // 6: reset during an offer drops everything
    ready = 1'b0; a = 8'h10;
    tick(); a = 8'h00;
    tick(); check("t6_valid", valid, 1'b1); check("t6_y", y, 3'd4);
    a = 8'h30;
    tick(); a = 8'h00;
    check("t6_pend", pend, 8'h30); check("t6_hold_y", y, 3'd4);
    rst = 1'b1; ready = 1'b1;
    tick(); rst = 1'b0;
    check("t6_rst_valid", valid, 1'b0); check("t6_rst_y", y, 3'd0);
    check("t6_rst_pend", pend, 8'h00); check("t6_rst_perdido", perdido, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_quiet_valid", valid, 1'b0);
      check("t6_quiet_nenhum", nenhum, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
